// File: rtl/game_pkg.sv
// Shared game-flow definitions: state encodings and music source selection.
// Also used by pixel_gen and SampleDisplay so all blocks agree on the encoding.
package game_pkg;

    typedef enum logic [2:0] {
        STATE_RESET = 3'b000,
        STATE_GAME  = 3'b001,
        STATE_OVER  = 3'b010,
        STATE_PAUSE = 3'b011
    } game_state_t;

    localparam logic MUSIC_TITLE = 1'b0;
    localparam logic MUSIC_GAME  = 1'b1;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a stability-counter debouncer for one
// board switch. The debounced value only follows the input after it has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
module sw_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic sw_db
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the asynchronous switch level into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
        end
    end

    // Count how long the synchronised input has disagreed with the accepted value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else if (sync2_q == db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            db_q  <= sync2_q;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign sw_db = db_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Registered game-flow controller: debounces the board switches, edge-detects
// the die flag, runs the RESET/GAME/OVER/PAUSE state machine, and keeps the
// elapsed game time shown on the seven-segment display.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TICK_DIV        = 100000000,
    parameter int unsigned TIME_MAX        = 999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_run,
    input  logic       sw_quit,
    input  logic       sw_pause,
    input  logic       die,
    output logic [2:0] state,
    output logic       play_rst,
    output logic       music_sel,
    output logic       music_en,
    output logic [9:0] game_time,
    output logic       time_tick
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [9:0] TIME_LIMIT = 10'(TIME_MAX);

    logic run_db;
    logic quit_db;
    logic pause_db;

    logic die_sync1_q;
    logic die_sync2_q;
    logic die_dly_q;
    logic die_rise;

    game_state_t state_q;
    game_state_t state_d;

    logic [PRESC_W-1:0] presc_q;
    logic [9:0]         game_time_q;
    logic               time_tick_q;

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw_run),
        .sw_db (run_db)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_quit_db (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw_quit),
        .sw_db (quit_db)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw_pause),
        .sw_db (pause_db)
    );

    // Synchronise die and keep one delayed copy so only a fresh rising edge counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            die_sync1_q <= 1'b0;
            die_sync2_q <= 1'b0;
            die_dly_q   <= 1'b0;
        end else begin
            die_sync1_q <= die;
            die_sync2_q <= die_sync1_q;
            die_dly_q   <= die_sync2_q;
        end
    end

    assign die_rise = die_sync2_q & ~die_dly_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= STATE_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; leaving run wins over death, death over quit, quit over pause.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_RESET: begin
                if (run_db) state_d = STATE_GAME;
            end
            STATE_GAME: begin
                if (!run_db)       state_d = STATE_RESET;
                else if (die_rise) state_d = STATE_OVER;
                else if (quit_db)  state_d = STATE_OVER;
                else if (pause_db) state_d = STATE_PAUSE;
            end
            STATE_PAUSE: begin
                if (!run_db)       state_d = STATE_RESET;
                else if (quit_db)  state_d = STATE_OVER;
                else if (!pause_db) state_d = STATE_GAME;
            end
            STATE_OVER: begin
                if (!run_db) state_d = STATE_RESET;
            end
            default: state_d = STATE_RESET;
        endcase
    end

    // Elapsed-time counter: runs only in GAME, clears in RESET, holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q     <= '0;
            game_time_q <= '0;
            time_tick_q <= 1'b0;
        end else if (state_q == STATE_RESET) begin
            presc_q     <= '0;
            game_time_q <= '0;
            time_tick_q <= 1'b0;
        end else if (state_q == STATE_GAME) begin
            if (presc_q == PRESC_LAST) begin
                presc_q     <= '0;
                time_tick_q <= 1'b1;
                if (game_time_q != TIME_LIMIT) begin
                    game_time_q <= game_time_q + 10'd1;
                end
            end else begin
                presc_q     <= presc_q + PRESC_W'(1);
                time_tick_q <= 1'b0;
            end
        end else begin
            time_tick_q <= 1'b0;
        end
    end

    assign state     = state_q;
    assign play_rst  = (state_q == STATE_RESET);
    assign music_sel = ((state_q == STATE_GAME) || (state_q == STATE_PAUSE)) ? MUSIC_GAME : MUSIC_TITLE;
    assign music_en  = (state_q != STATE_PAUSE);
    assign game_time = game_time_q;
    assign time_tick = time_tick_q;

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Registered game-flow controller for the Mario top level.
- Replaces the combinational RESET/GAME/OVER/PAUSE decode with a debounced, sticky state machine.
- Drives the game-logic reset, the music source select and enable, and an elapsed-time counter for the seven-segment display.
- Sits between the board switches and die flag on one side, and pixel_gen, the music players and SampleDisplay on the other.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles a synchronised switch must stay stable before being accepted (10 ms at 100 MHz).
- TICK_DIV, 100000000: clk cycles per game-time tick (1 s at 100 MHz).
- TIME_MAX, 999: saturation value of game_time.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous reset, active-low.
- sw_run  in  1  SW[0]; 1 = run, 0 = return to title.
- sw_quit  in  1  SW[1]; 1 = forfeit to game over.
- sw_pause  in  1  SW[2]; 1 = pause.
- die  in  1  from pixel_gen; level, high once the player has died.
- state  out  3  RESET=000, GAME=001, OVER=010, PAUSE=011.
- play_rst  out  1  active-high reset to pixel_gen and SampleDisplay game logic.
- music_sel  out  1  0 = title music, 1 = in-game music.
- music_en  out  1  0 mutes the selected player.
- game_time  out  10  elapsed whole ticks in GAME, 0..TIME_MAX.
- time_tick  out  1  one-cycle pulse on each game_time increment.

Behaviour:
- Reset (rst=0, asynchronous) sets these values:
  - state = RESET, play_rst = 1, music_sel = 0, music_en = 1.
  - game_time = 0, time_tick = 0, prescaler = 0.
  - Debounced switches = 0, die synchroniser flops = 0.
- Switch inputs:
  - Each switch passes through a 2-flop synchroniser, then a debouncer.
  - The debounce counter clears whenever the synchronised input equals the debounced value.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced value takes the input and the counter clears.
  - Latency from a stable switch edge to the debounced edge is 2+DEBOUNCE_CYCLES cycles.
- Die input:
  - die passes through a 2-flop synchroniser plus one delay flop.
  - die_rise = synced & ~delayed. Only a rising edge is an event, so a stale high level never retriggers.
- FSM:
  - One registered state. Next state is evaluated every cycle, with priority run=0 > die_rise > quit > pause.
  - RESET: run=1 -> GAME; otherwise stay.
  - GAME: run=0 -> RESET; die_rise -> OVER; quit=1 -> OVER; pause=1 -> PAUSE; otherwise stay.
  - PAUSE: run=0 -> RESET; quit=1 -> OVER; pause=0 -> GAME. die_rise in PAUSE is ignored, because the game logic is frozen.
  - OVER: sticky. Only run=0 -> RESET. Releasing quit or die does not leave OVER.
  - Entering GAME from RESET with quit or pause already high: next cycle goes to OVER or PAUSE respectively.
- Output decode (combinational from the state register, no extra latency):
  - play_rst = (state==RESET).
  - music_sel = (state==GAME or PAUSE).
  - music_en = (state!=PAUSE).
- Time counter:
  - The prescaler counts 0..TICK_DIV-1 only while state==GAME, and holds its value in PAUSE.
  - On wrap, game_time increments and time_tick pulses for one cycle.
  - game_time saturates at TIME_MAX; time_tick still pulses at saturation.
  - In RESET, the prescaler and game_time clear to 0 synchronously.
  - In OVER, both hold their values so the final time stays displayed.
- Simultaneous events:
  - die_rise and pause in the same cycle -> OVER.
  - A prescaler wrap in the same cycle as GAME->PAUSE or GAME->OVER still increments, because counting is gated by the current state.
- Reset mid-operation: any state returns to RESET immediately. Debounced switches are cleared, so re-entry to GAME needs a fresh run debounce.

Decomposition:
- Shared package game_pkg holds:
  - The state encodings STATE_RESET, STATE_GAME, STATE_OVER and STATE_PAUSE.
  - The music_sel constants MUSIC_TITLE and MUSIC_GAME.
  - These are reused by pixel_gen and SampleDisplay.
- One sub-module, sw_debounce: synchroniser plus counter, parameter DEBOUNCE_CYCLES. It is instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=10, TIME_MAX=5):
1. Power-up: rst low 3 cycles, then high with all switches 0 -> state=000, play_rst=1, music_sel=0, music_en=1, game_time=0.
2. sw_run 0->1 held -> state=001 exactly 7 cycles after the edge (2 sync + 4 debounce + 1 register); play_rst=0, music_sel=1; time_tick every 10 cycles; game_time 1..5, then holds at 5.
3. In GAME, sw_pause=1 for 20 cycles, then 0 -> PAUSE with music_en=0 and game_time frozen; back to GAME, and counting resumes from the held prescaler value.
4. In GAME, pulse die high 1 cycle then low -> OVER; game_time holds; die low and quit=0 keep OVER; sw_run=0 -> RESET with game_time=0.
5. Bounce: toggle sw_run every 2 cycles for 20 cycles, then hold 1 -> no state change during the bounce; GAME 7 cycles after the final edge.
6. die held high from before GAME entry (no edge) -> stays GAME; assert sw_quit -> OVER; in PAUSE, a die pulse -> stays PAUSE.
